reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised clock-domain reset controller that sits between the board/bench reset and the processor core (and its peripherals). Asserts all downstream resets asynchronously, releases them synchronously after a programmable hold time, de-asserts the outputs one by one at a fixed stagger, then counts run cycles and optionally halts the system by re-asserting every reset after a cycle budget. Gives each `top` instance a synthesizable, deterministic reset and run-window sequence with no bench-side delays.

## Interface
- `NUM_OUT`, 2: number of reset outputs; index 0 releases first; ≥1.
- `HOLD_CYCLES`, 3: cycles all outputs stay asserted after synchronized release; ≥1.
- `STAGGER`, 1: cycles between successive output releases; ≥1.
- `RUN_CYCLES`, 50: run-cycle budget before halt; 0 = unlimited.
- `CNT_W`, 16: width of `cycle_count`; must hold `RUN_CYCLES`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high system reset.
- `soft_rst_req` in 1: synchronous request to restart the sequence.
- `rst_out` out `NUM_OUT`: active-high downstream resets.
- `run` out 1: all outputs released and not halted.
- `busy` out 1: sequence in progress (RESET, HOLD or RELEASE).
- `timeout` out 1: sticky; run budget exhausted.
- `cycle_count` out `CNT_W`: cycles spent in RUN.

One clock; reset is asynchronous and active-high.

## Operation
- States: RESET, HOLD, RELEASE, RUN, DONE.
- While `reset`=1, asynchronously: state RESET, `rst_out` all ones, `run`=0, `busy`=1, `timeout`=0, `cycle_count`=0, both stages of the internal 2-flop release synchronizer cleared.
- RESET→HOLD once the synchronizer output is 1.
- HOLD: all `rst_out`=1 for `HOLD_CYCLES` edges, then RELEASE.
- RELEASE: clear `rst_out[i]` in index order, one bit every `STAGGER` edges. The edge that clears `rst_out[NUM_OUT-1]` also enters RUN: `run`=1, `busy`=0, `cycle_count`=0.
- RUN: `cycle_count` increments by 1 each edge.
  - If `RUN_CYCLES`≠0, the edge on which it reaches `RUN_CYCLES` enters DONE.
  - If `RUN_CYCLES`=0, the count saturates at all ones and never wraps.
- DONE: `rst_out` all ones, `run`=0, `timeout`=1, `cycle_count` holds `RUN_CYCLES`. Leaves only via `soft_rst_req` or `reset`.
- `soft_rst_req`: sampled in HOLD, RELEASE, RUN or DONE; ignored in RESET.
  - On the sampling edge: state HOLD, `rst_out` all ones, `run`=0, `busy`=1, `timeout`=0, `cycle_count`=0, hold counter restarted.
  - Held high, it keeps restarting HOLD every edge, so no output is released.
- A soft request has priority over a same-edge release or DONE transition.
- `reset` has priority over everything, at any time.

## Timing
- Let E0 be the first rising edge with `reset` low.
  - Synchronizer: stage 1 goes high at E0, stage 2 at E1.
  - HOLD is entered at E2.
  - `rst_out[i]` falls at edge E(2+`HOLD_CYCLES`+i·`STAGGER`).
  - `run` rises at the edge where `rst_out[NUM_OUT-1]` falls.
- Soft restart sampled at edge S: `rst_out[i]` falls at S+`HOLD_CYCLES`+i·`STAGGER`.
- DONE is entered `RUN_CYCLES` edges after RUN entry. `rst_out` re-asserts, `run` falls and `timeout` rises on that same edge.
- Reset assertion takes effect on outputs with no clock. Deassertion is always clock-aligned.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Defaults, `reset` high 50 ns then low (20 ns period):
  - all `rst_out`=2'b11, `busy`=1 while reset is high;
  - `rst_out[0]` falls at E5, `rst_out[1]` and `run` at E6.
- `RUN_CYCLES`=50: `cycle_count` 0→50; at the 50th RUN edge `rst_out`=2'b11, `run`=0, `timeout`=1; the count then holds 50 for 20 more cycles.
- `soft_rst_req` one-cycle pulse at RUN count 10 → `timeout`=0, count 0, `rst_out`=2'b11; releases at S+3 and S+4; `run` back at S+4.
- `reset` pulsed for 3 ns mid-RELEASE (`rst_out`=2'b10) → outputs go 2'b11 immediately, without a clock edge; the full E0-based sequence then repeats.
- `NUM_OUT`=4, `STAGGER`=3, `HOLD_CYCLES`=1, `RUN_CYCLES`=0 → releases at E3, E6, E9, E12; `run` stays high indefinitely.
  - With `CNT_W`=4, `cycle_count` saturates at 15.
- `soft_rst_req` held high 10 cycles in RUN → `rst_out` stays all ones throughout; the first release comes `HOLD_CYCLES` edges after the last high sample.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: asserts downstream resets asynchronously, releases them in staggered
// index order after a hold time, then counts run cycles with an optional halt budget.
module reset_sequencer #(
    parameter int NUM_OUT     = 2,
    parameter int HOLD_CYCLES = 3,
    parameter int STAGGER     = 1,
    parameter int RUN_CYCLES  = 50,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               run,
    output logic               busy,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count
);

    // state     | meaning
    // S_RESET   | waiting for the synchronized release of the system reset
    // S_HOLD    | all outputs asserted, hold timer running
    // S_RELEASE | outputs being cleared in index order, one per stagger interval
    // S_RUN     | all outputs released, counting run cycles
    // S_DONE    | run budget exhausted, all outputs re-asserted until restart
    typedef enum logic [2:0] {
        S_RESET,
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int TMR_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAG_LOAD = TMR_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_CYCLES);

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [TMR_W-1:0]   r_timer;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_OUT-1:0] r_rst_out;
    logic               r_run;
    logic               r_busy;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_count;

    state_t             w_state;
    logic [TMR_W-1:0]   w_timer;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_OUT-1:0] w_rst_out;
    logic               w_run;
    logic               w_busy;
    logic               w_timeout;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= S_RESET;
            r_timer   <= HOLD_LOAD;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_run     <= 1'b0;
            r_busy    <= 1'b1;
            r_timeout <= 1'b0;
            r_count   <= '0;
        end else begin
            r_sync1   <= 1'b1;
            r_sync2   <= r_sync1;
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_idx     <= w_idx;
            r_rst_out <= w_rst_out;
            r_run     <= w_run;
            r_busy    <= w_busy;
            r_timeout <= w_timeout;
            r_count   <= w_count;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_idx     = r_idx;
        w_rst_out = r_rst_out;
        w_run     = r_run;
        w_busy    = r_busy;
        w_timeout = r_timeout;
        w_count   = r_count;

        case (r_state)
            S_RESET: begin
                if (r_sync2) begin
                    w_state = S_HOLD;
                    w_timer = HOLD_LOAD;
                    w_idx   = '0;
                end
            end
            // HOLD's terminal count releases output 0 on the same edge it exits
            S_HOLD, S_RELEASE: begin
                if (r_timer == '0) begin
                    w_rst_out[r_idx] = 1'b0;
                    if (r_idx == LAST_IDX) begin
                        w_state = S_RUN;
                        w_run   = 1'b1;
                        w_busy  = 1'b0;
                        w_count = '0;
                    end else begin
                        w_state = S_RELEASE;
                        w_idx   = r_idx + IDX_W'(1);
                        w_timer = STAG_LOAD;
                    end
                end else begin
                    w_timer = r_timer - TMR_W'(1);
                end
            end
            S_RUN: begin
                if (RUN_CYCLES == 0) begin
                    if (r_count != '1) begin
                        w_count = w_count_inc;
                    end
                end else begin
                    w_count = w_count_inc;
                    if (w_count_inc == RUN_LIMIT) begin
                        w_state   = S_DONE;
                        w_rst_out = '1;
                        w_run     = 1'b0;
                        w_timeout = 1'b1;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                w_state = S_RESET;
            end
        endcase

        if (soft_rst_req && (r_state != S_RESET)) begin
            w_state   = S_HOLD;
            w_timer   = HOLD_LOAD;
            w_idx     = '0;
            w_rst_out = '1;
            w_run     = 1'b0;
            w_busy    = 1'b1;
            w_timeout = 1'b0;
            w_count   = '0;
        end
    end

    assign rst_out     = r_rst_out;
    assign run         = r_run;
    assign busy        = r_busy;
    assign timeout     = r_timeout;
    assign cycle_count = r_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a 4-output, unlimited-run,
// 4-bit-counter instance, checked with immediate assertions against hand-computed values.
module tb_reset_sequencer;

    logic        clk;
    logic        rst_a;
    logic        soft_a;
    logic [1:0]  rst_out_a;
    logic        run_a;
    logic        busy_a;
    logic        timeout_a;
    logic [15:0] count_a;

    logic        rst_b;
    logic        soft_b;
    logic [3:0]  rst_out_b;
    logic        run_b;
    logic        busy_b;
    logic        timeout_b;
    logic [3:0]  count_b;

    int n_chk  = 0;
    int n_pass = 0;

    reset_sequencer u_dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .soft_rst_req (soft_a),
        .rst_out      (rst_out_a),
        .run          (run_a),
        .busy         (busy_a),
        .timeout      (timeout_a),
        .cycle_count  (count_a)
    );

    reset_sequencer #(
        .NUM_OUT     (4),
        .HOLD_CYCLES (1),
        .STAGGER     (3),
        .RUN_CYCLES  (0),
        .CNT_W       (4)
    ) u_dut_b (
        .clk          (clk),
        .reset        (rst_b),
        .soft_rst_req (soft_b),
        .rst_out      (rst_out_b),
        .run          (run_b),
        .busy         (busy_b),
        .timeout      (timeout_b),
        .cycle_count  (count_b)
    );

    // rising edges at 20, 40, 60, ...
    initial clk = 1'b1;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic [1:0] r, input logic ru, input logic bu,
                         input logic to, input logic [15:0] c);
        chk({tag, ".rst_out"}, 32'(rst_out_a), 32'(r));
        chk({tag, ".run"},     32'(run_a),     32'(ru));
        chk({tag, ".busy"},    32'(busy_a),    32'(bu));
        chk({tag, ".timeout"}, 32'(timeout_a), 32'(to));
        chk({tag, ".count"},   32'(count_a),   32'(c));
    endtask

    initial begin
        rst_a  = 1'b1;
        soft_a = 1'b0;
        rst_b  = 1'b1;
        soft_b = 1'b0;

        #5;
        chk_a("a_reset_t5", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        chk("b_reset_t5", 32'(rst_out_b), 32'hF);
        @(posedge clk);
        #5;
        chk_a("a_reset_t25", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);

        // reset low at t=50; E0 is the edge at t=60
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        tick();
        chk_a("a_e0", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        repeat (4) tick();
        chk_a("a_e4", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_e5", 2'b10, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_e6", 2'b00, 1'b1, 1'b0, 1'b0, 16'd0);

        repeat (49) tick();
        chk_a("a_run49", 2'b00, 1'b1, 1'b0, 1'b0, 16'd49);
        tick();
        chk_a("a_done", 2'b11, 1'b0, 1'b0, 1'b1, 16'd50);
        repeat (20) tick();
        chk_a("a_done_hold", 2'b11, 1'b0, 1'b0, 1'b1, 16'd50);

        // soft restart out of DONE
        soft_a = 1'b1;
        tick();
        soft_a = 1'b0;
        chk_a("a_soft_done_s", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        repeat (2) tick();
        chk_a("a_soft_done_s2", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_soft_done_s3", 2'b10, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_soft_done_s4", 2'b00, 1'b1, 1'b0, 1'b0, 16'd0);

        // one-cycle soft pulse at run count 10
        repeat (10) tick();
        chk_a("a_run10", 2'b00, 1'b1, 1'b0, 1'b0, 16'd10);
        soft_a = 1'b1;
        tick();
        soft_a = 1'b0;
        chk_a("a_soft_run_s", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        repeat (2) tick();
        chk_a("a_soft_run_s2", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_soft_run_s3", 2'b10, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_soft_run_s4", 2'b00, 1'b1, 1'b0, 1'b0, 16'd1 - 16'd1);

        // 3 ns reset pulse mid-RELEASE, no clock edge inside the pulse
        soft_a = 1'b1;
        tick();
        soft_a = 1'b0;
        repeat (3) tick();
        chk_a("a_pre_pulse", 2'b10, 1'b0, 1'b1, 1'b0, 16'd0);
        #2 rst_a = 1'b1;
        #1;
        chk_a("a_pulse_async", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        #2 rst_a = 1'b0;
        #1;
        chk_a("a_pulse_after", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_re_e0", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        repeat (4) tick();
        chk_a("a_re_e4", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_re_e5", 2'b10, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_re_e6", 2'b00, 1'b1, 1'b0, 1'b0, 16'd0);

        // soft request held for 10 edges in RUN
        repeat (3) tick();
        soft_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("a_soft_held.rst_out", 32'(rst_out_a), 32'h3);
            chk("a_soft_held.busy", 32'(busy_a), 32'h1);
        end
        soft_a = 1'b0;
        repeat (2) tick();
        chk_a("a_held_l2", 2'b11, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_held_l3", 2'b10, 1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        chk_a("a_held_l4", 2'b00, 1'b1, 1'b0, 1'b0, 16'd0);

        // second instance: releases at E3, E6, E9, E12; count saturates at 15
        @(negedge clk);
        rst_b = 1'b0;
        tick();
        repeat (2) tick();
        chk("b_e2.rst_out", 32'(rst_out_b), 32'hF);
        chk("b_e2.busy", 32'(busy_b), 32'h1);
        tick();
        chk("b_e3.rst_out", 32'(rst_out_b), 32'hE);
        repeat (2) tick();
        chk("b_e5.rst_out", 32'(rst_out_b), 32'hE);
        tick();
        chk("b_e6.rst_out", 32'(rst_out_b), 32'hC);
        repeat (3) tick();
        chk("b_e9.rst_out", 32'(rst_out_b), 32'h8);
        repeat (2) tick();
        chk("b_e11.rst_out", 32'(rst_out_b), 32'h8);
        chk("b_e11.run", 32'(run_b), 32'h0);
        tick();
        chk("b_e12.rst_out", 32'(rst_out_b), 32'h0);
        chk("b_e12.run", 32'(run_b), 32'h1);
        chk("b_e12.count", 32'(count_b), 32'h0);
        repeat (14) tick();
        chk("b_run14.count", 32'(count_b), 32'd14);
        tick();
        chk("b_run15.count", 32'(count_b), 32'd15);
        repeat (5) tick();
        chk("b_sat.count", 32'(count_b), 32'd15);
        chk("b_sat.run", 32'(run_b), 32'h1);
        chk("b_sat.timeout", 32'(timeout_b), 32'h0);
        chk("b_sat.rst_out", 32'(rst_out_b), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
